conv_window_gen: RTL and testbench

//  Front end of the 3x3 conv stage. Takes the raster pixel stream (one pixel per

---
 rtl/conv_window_gen.sv | 97 +++++++++
 tb/tb_conv_window_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator for the conv stage: two line buffers plus a column
// history build each window from a raster pixel stream, emitting only full (unpadded) windows.
module conv_window_gen #(
   parameter int IMG_W = 28,
   parameter int IMG_H = 28,
   parameter int PIX_W = 8,
   localparam int CW = $clog2(IMG_W),
   localparam int RW = $clog2(IMG_H)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [PIX_W-1:0]   i_pixel_data,
   input  logic               i_pixel_data_valid,
   input  logic               i_sof,
   output logic [9*PIX_W-1:0] o_window,
   output logic               o_window_valid,
   output logic [RW-1:0]      o_win_row,
   output logic [CW-1:0]      o_win_col,
   output logic               o_frame_done
);

   logic [PIX_W-1:0] lb1 [IMG_W];
   logic [PIX_W-1:0] lb2 [IMG_W];
   logic [PIX_W-1:0] hist [3][2];
   logic [PIX_W-1:0] new_col [3];

   logic [RW-1:0]      row, eff_row;
   logic [CW-1:0]      col, eff_col;
   logic [PIX_W-1:0]   lb1_rd, lb2_rd;
   logic [9*PIX_W-1:0] nxt_win;
   logic               emit, last_pix;

   // sof forces the accepted pixel to (0,0) regardless of where the counters are
   always_comb begin
      eff_row  = i_sof ? '0 : row;
      eff_col  = i_sof ? '0 : col;
      lb1_rd   = lb1[eff_col];
      lb2_rd   = lb2[eff_col];
      new_col[0] = lb2_rd;
      new_col[1] = lb1_rd;
      new_col[2] = i_pixel_data;
      nxt_win  = '0;
      for (int r = 0; r < 3; r++) begin
         nxt_win[(r*3)*PIX_W   +: PIX_W] = hist[r][0];
         nxt_win[(r*3+1)*PIX_W +: PIX_W] = hist[r][1];
         nxt_win[(r*3+2)*PIX_W +: PIX_W] = new_col[r];
      end
      emit     = i_pixel_data_valid && (eff_row >= RW'(2)) && (eff_col >= CW'(2));
      last_pix = (eff_row == RW'(IMG_H-1)) && (eff_col == CW'(IMG_W-1));
   end

   // Line-buffer RAM: read-before-write, deliberately not reset
   always_ff @(posedge i_clk) begin
      if (i_pixel_data_valid) begin
         lb2[eff_col] <= lb1_rd;
         lb1[eff_col] <= i_pixel_data;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         row            <= '0;
         col            <= '0;
         o_window       <= '0;
         o_window_valid <= 1'b0;
         o_win_row      <= '0;
         o_win_col      <= '0;
         o_frame_done   <= 1'b0;
         for (int r = 0; r < 3; r++) begin
            hist[r][0] <= '0;
            hist[r][1] <= '0;
         end
      end else begin
         o_window_valid <= emit;
         o_frame_done   <= emit && last_pix;
         if (emit) begin
            o_window  <= nxt_win;
            o_win_row <= eff_row;
            o_win_col <= eff_col;
         end
         if (i_pixel_data_valid) begin
            for (int r = 0; r < 3; r++) begin
               hist[r][0] <= hist[r][1];
               hist[r][1] <= new_col[r];
            end
            if (eff_col == CW'(IMG_W-1)) begin
               col <= '0;
               row <= (eff_row == RW'(IMG_H-1)) ? '0 : eff_row + RW'(1);
            end else begin
               col <= eff_col + CW'(1);
               row <= eff_row;
            end
         end
      end
   end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: full frames, valid gaps, back-to-back frames,
// mid-frame reset and mid-frame sof abort, checked against a pixel-formula model.
module tb_conv_window_gen;
   localparam int W = 28, H = 28, P = 8;

   logic          i_clk = 0, i_rst = 0;
   logic [P-1:0]  i_pixel_data = '0;
   logic          i_pixel_data_valid = 0, i_sof = 0;
   logic [9*P-1:0] o_window;
   logic          o_window_valid, o_frame_done;
   logic [4:0]    o_win_row, o_win_col;

   conv_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_pixel_data(i_pixel_data),
      .i_pixel_data_valid(i_pixel_data_valid), .i_sof(i_sof),
      .o_window(o_window), .o_window_valid(o_window_valid),
      .o_win_row(o_win_row), .o_win_col(o_win_col), .o_frame_done(o_frame_done));

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [9*P-1:0] w;
      int             r;
      int             c;
      logic           fd;
      logic [P-1:0]   lp;
   } ent_t;

   ent_t cap[$];
   int   fd_cnt = 0, bad_strobe = 0, asserts = 0, fails = 0;
   logic acc_q = 0;
   logic [P-1:0] pix_q = '0;

   // Observer: records every strobe with the pixel accepted on the previous edge
   always @(posedge i_clk) begin
      acc_q <= i_pixel_data_valid;
      if (i_pixel_data_valid) pix_q <= i_pixel_data;
   end
   always @(negedge i_clk) begin
      if (o_window_valid) begin
         cap.push_back('{o_window, int'(o_win_row), int'(o_win_col), o_frame_done, pix_q});
         if (!acc_q) bad_strobe++;
      end
      if (o_frame_done) fd_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [9*P-1:0] exp_win(int r, int c, int off);
      logic [9*P-1:0] w;
      for (int k = 0; k < 9; k++)
         w[k*P +: P] = 8'((((r - 2 + k/3) * W + (c - 2 + k%3)) + off) & 255);
      return w;
   endfunction

   // Index of the first captured entry that deviates from a clean frame, or -1
   function automatic int first_bad(int start, int off);
      for (int i = 0; i < (W-2)*(H-2); i++) begin
         int r = 2 + i / (W-2);
         int c = 2 + i % (W-2);
         if (start + i >= cap.size()) return start + i;
         if (cap[start+i].w !== exp_win(r, c, off) || cap[start+i].r != r ||
             cap[start+i].c != c || cap[start+i].fd !== ((r == H-1) && (c == W-1)))
            return start + i;
      end
      return -1;
   endfunction

   task automatic send_frame(input int off, input int gap_pct, input int npix);
      for (int p = 0; p < npix; p++) begin
         while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            i_pixel_data_valid = 0;
            i_sof = 0;
            @(posedge i_clk); #1;
         end
         i_pixel_data_valid = 1;
         i_sof = (p == 0);
         i_pixel_data = 8'((p / W * W + p % W + off) & 255);
         @(posedge i_clk); #1;
      end
      i_pixel_data_valid = 0;
      i_sof = 0;
   endtask

   task automatic drain_and_clear_after;
      repeat (3) @(posedge i_clk);
      #1;
   endtask

   task automatic clear_obs;
      cap.delete();
      fd_cnt = 0;
      bad_strobe = 0;
   endtask

   task automatic test_reset;
      i_rst = 1;
      repeat (2) @(posedge i_clk);
      #1;
      asserts++; if (o_window !== '0) begin fails++; $display("FAIL reset_window: got %h want 0", o_window); end
      asserts++; if (o_window_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", o_window_valid); end
      asserts++; if (o_win_row !== '0 || o_win_col !== '0) begin fails++; $display("FAIL reset_rowcol: got %0d,%0d want 0,0", o_win_row, o_win_col); end
      asserts++; if (o_frame_done !== 1'b0) begin fails++; $display("FAIL reset_fd: got %b want 0", o_frame_done); end
      i_rst = 0;
      @(posedge i_clk); #1;
   endtask

   task automatic check_clean_frame(input string tag, input int gap_pct);
      logic [9*P-1:0] first_lit, last_lit;
      int b;
      first_lit = {8'd58, 8'd57, 8'd56, 8'd30, 8'd29, 8'd28, 8'd2, 8'd1, 8'd0};
      last_lit  = {8'd15, 8'd14, 8'd13, 8'd243, 8'd242, 8'd241, 8'd215, 8'd214, 8'd213};
      clear_obs();
      send_frame(0, gap_pct, W*H);
      drain_and_clear_after();
      asserts++; if (cap.size() != 676) begin fails++; $display("FAIL %s_count: got %0d want 676", tag, cap.size()); end
      if (cap.size() > 0) begin
         asserts++; if (cap[0].w !== first_lit) begin fails++; $display("FAIL %s_first_win: got %h want %h", tag, cap[0].w, first_lit); end
         asserts++; if (cap[0].r != 2 || cap[0].c != 2) begin fails++; $display("FAIL %s_first_pos: got %0d,%0d want 2,2", tag, cap[0].r, cap[0].c); end
         asserts++; if (cap[0].lp !== 8'd58) begin fails++; $display("FAIL %s_latency: strobe follows pixel %0d want 58", tag, cap[0].lp); end
         asserts++; if (cap[cap.size()-1].w !== last_lit || cap[cap.size()-1].fd !== 1'b1 ||
                       cap[cap.size()-1].r != 27 || cap[cap.size()-1].c != 27) begin
            fails++; $display("FAIL %s_last: got %h fd=%b %0d,%0d want %h fd=1 27,27", tag,
                              cap[cap.size()-1].w, cap[cap.size()-1].fd, cap[cap.size()-1].r, cap[cap.size()-1].c, last_lit);
         end
      end
      b = first_bad(0, 0);
      asserts++; if (b != -1) begin fails++; $display("FAIL %s_sequence: first deviation at index %0d want none", tag, b); end
      asserts++; if (fd_cnt != 1) begin fails++; $display("FAIL %s_fd_count: got %0d want 1", tag, fd_cnt); end
      asserts++; if (bad_strobe != 0) begin fails++; $display("FAIL %s_strobe_timing: got %0d stray strobes want 0", tag, bad_strobe); end
   endtask

   task automatic test_frame;
      check_clean_frame("frame", 0);
   endtask

   task automatic test_gaps;
      check_clean_frame("gaps", 30);
   endtask

   task automatic test_back_to_back;
      int b;
      clear_obs();
      send_frame(0, 0, W*H);
      send_frame(100, 0, W*H);
      drain_and_clear_after();
      asserts++; if (cap.size() != 1352) begin fails++; $display("FAIL b2b_count: got %0d want 1352", cap.size()); end
      if (cap.size() > 676) begin
         asserts++; if (cap[676].w !== exp_win(2, 2, 100)) begin fails++; $display("FAIL b2b_second_first: got %h want %h", cap[676].w, exp_win(2, 2, 100)); end
      end
      b = first_bad(676, 100);
      asserts++; if (b != -1) begin fails++; $display("FAIL b2b_sequence: first deviation at index %0d want none", b); end
      asserts++; if (fd_cnt != 2) begin fails++; $display("FAIL b2b_fd_count: got %0d want 2", fd_cnt); end
   endtask

   task automatic test_mid_reset;
      clear_obs();
      send_frame(0, 0, 400);
      i_rst = 1;
      #1;
      asserts++; if (o_window !== '0 || o_window_valid !== 1'b0 || o_win_row !== '0 || o_win_col !== '0)
         begin fails++; $display("FAIL async_reset: got win=%h v=%b %0d,%0d want all 0", o_window, o_window_valid, o_win_row, o_win_col); end
      repeat (3) @(posedge i_clk);
      #1;
      i_rst = 0;
      @(posedge i_clk); #1;
      check_clean_frame("post_reset", 0);
   endtask

   task automatic test_sof_abort;
      int b;
      clear_obs();
      send_frame(0, 0, 300);
      send_frame(50, 0, W*H);
      drain_and_clear_after();
      asserts++; if (cap.size() != 226 + 676) begin fails++; $display("FAIL abort_count: got %0d want 902", cap.size()); end
      if (cap.size() > 226) begin
         asserts++; if (cap[226].w !== exp_win(2, 2, 50) || cap[226].r != 2 || cap[226].c != 2) begin
            fails++; $display("FAIL abort_resume: got %h %0d,%0d want %h 2,2", cap[226].w, cap[226].r, cap[226].c, exp_win(2, 2, 50));
         end
         asserts++; if (cap[225].r != 10 || cap[225].c != 19 || cap[225].fd !== 1'b0) begin
            fails++; $display("FAIL abort_last_partial: got %0d,%0d fd=%b want 10,19 fd=0", cap[225].r, cap[225].c, cap[225].fd);
         end
      end
      b = first_bad(226, 50);
      asserts++; if (b != -1) begin fails++; $display("FAIL abort_sequence: first deviation at index %0d want none", b); end
      asserts++; if (fd_cnt != 1) begin fails++; $display("FAIL abort_fd_count: got %0d want 1", fd_cnt); end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_gaps();
      test_back_to_back();
      test_mid_reset();
      test_sof_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end
endmodule
